// File: rtl/enigma_input_stage.sv
// Enigma front end: filters ASCII letters, maps them through a plugboard, queues
// them and sequences each one into the rotor stage (step, data-valid, wait-done).
module enigma_input_stage #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_a,
    input  logic [4:0]  cfg_b,
    input  logic        cfg_clr,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        rot_en,
    output logic        rot_valid,
    output logic [7:0]  rot_din,
    input  logic        rot_done,
    output logic        busy,
    output logic [15:0] drop_cnt,
    output logic        err_cfg,
    output logic        err_timeout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_ISSUE, S_WAIT} state_t;

    state_t        state_q;
    logic [4:0]    table_q [32];
    logic [4:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [TW-1:0] tmo_q;
    logic          err_cfg_q, err_timeout_q;
    logic          rot_en_q, rot_valid_q;
    logic [7:0]    rot_din_q;

    logic          is_upper, is_lower, is_letter;
    logic [4:0]    idx;
    logic          push, drop, pop, full, busy_int;
    logic          cfg_legal, cfg_apply;

    always_comb begin
        is_upper  = (char_in >= 8'h41) && (char_in <= 8'h5A);
        is_lower  = (char_in >= 8'h61) && (char_in <= 8'h7A);
        is_letter = is_upper || is_lower;
        idx       = '0;
        if (is_upper) begin
            idx = 5'(char_in - 8'h41);
        end else if (is_lower) begin
            idx = 5'(char_in - 8'h61);
        end
    end

    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign char_ready = !full;
    assign push       = char_valid && char_ready && is_letter;
    assign drop       = char_valid && char_ready && !is_letter;
    assign pop        = (state_q == S_ISSUE);
    assign busy_int   = (state_q != S_IDLE) || (count_q != '0);

    always_comb begin
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // A pair may only be formed from two distinct letters that are both still self-mapped.
    assign cfg_legal = (cfg_a <= 5'd25) && (cfg_b <= 5'd25) && (cfg_a != cfg_b) &&
                       (table_q[cfg_a] == cfg_a) && (table_q[cfg_b] == cfg_b);
    assign cfg_apply = cfg_we && !busy_int && !cfg_clr;

    always_ff @(posedge clk) begin
        if (reset || cfg_clr) begin
            for (int unsigned i = 0; i < 32; i++) begin
                table_q[i] <= 5'(i);
            end
            err_cfg_q <= 1'b0;
        end else if (cfg_apply) begin
            if (cfg_legal) begin
                table_q[cfg_a] <= cfg_b;
                table_q[cfg_b] <= cfg_a;
            end else begin
                err_cfg_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= table_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs are loaded on the edge entering the state that asserts them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rot_en_q      <= 1'b0;
            rot_valid_q   <= 1'b0;
            rot_din_q     <= '0;
            tmo_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            rot_en_q    <= 1'b0;
            rot_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q  <= S_STEP;
                        rot_en_q <= 1'b1;
                    end
                end
                S_STEP: begin
                    state_q     <= S_ISSUE;
                    rot_valid_q <= 1'b1;
                    rot_din_q   <= {3'b000, mem_q[rd_ptr_q]};
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    tmo_q   <= '0;
                end
                S_WAIT: begin
                    if (rot_done) begin
                        state_q <= S_IDLE;
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rot_en      = rot_en_q;
    assign rot_valid   = rot_valid_q;
    assign rot_din     = rot_din_q;
    assign busy        = busy_int;
    assign drop_cnt    = drop_cnt_q;
    assign err_cfg     = err_cfg_q;
    assign err_timeout = err_timeout_q;
endmodule
